// File: rtl/game_fsm_if.sv
// Pin bundle for the pong game controller.
// Master drives button/point inputs; slave (the FSM) drives state/scores.
interface game_fsm_if;
  logic       btnC;
  logic       player_1_point;
  logic       player_2_point;
  logic [3:0] state;
  logic [3:0] score_1;
  logic [3:0] score_2;
  logic [1:0] winner;

  modport master (
    output btnC, player_1_point, player_2_point,
    input  state, score_1, score_2, winner
  );

  modport slave (
    input  btnC, player_1_point, player_2_point,
    output state, score_1, score_2, winner
  );
endinterface

// File: rtl/game_fsm.sv
// Pong game controller: serve sync, scoring, win detection.
// Optional AUTO_SERVE_EN adds a timed auto-serve out of NEW_BALL.
module game_fsm #(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 50000000
) (
  input  logic   clk,
  input  logic   reset,
  game_fsm_if.slave bus
);

  typedef enum logic [3:0] {
    NEW_GAME  = 4'b0001,
    PLAY      = 4'b0010,
    NEW_BALL  = 4'b0100,
    GAME_OVER = 4'b1000
  } state_e;

  localparam logic [3:0] WIN_M1 = 4'(WIN_SCORE - 1);

  if (WIN_SCORE < 1 || WIN_SCORE > 15) begin : g_bad_win
    $error("WIN_SCORE out of range");
  end
  if (SERVE_DELAY < 1 || SERVE_DELAY > 134217727) begin : g_bad_dly
    $error("SERVE_DELAY out of range");
  end

  state_e     state_q, state_d;
  logic [3:0] s1_q, s1_d;
  logic [3:0] s2_q, s2_d;
  logic [1:0] win_q, win_d;

  // sync_q[0..1]: two-flop synchronizer, sync_q[2]: edge history
  logic [2:0] sync_q;
  logic [1:0] vld_q;
  logic       arm_q;
  logic       serve;

  // Synchronize btnC; arm only after a post-reset low is seen
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      vld_q  <= '0;
      arm_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], bus.btnC};
      vld_q  <= {vld_q[0], 1'b1};
      if (vld_q[1] && !sync_q[1])
        arm_q <= 1'b1;
    end
  end

  assign serve = sync_q[1] & ~sync_q[2] & arm_q;

`ifdef AUTO_SERVE_EN
  localparam logic [26:0] LAST = 27'(SERVE_DELAY - 1);
  logic [26:0] cnt_q, cnt_d;

  // Serve counter: zero on NEW_BALL entry, count while inside
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == NEW_BALL && state_q != NEW_BALL)
      cnt_d = '0;
    else if (state_q == NEW_BALL)
      cnt_d = cnt_q + 27'd1;
  end

  // Serve counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  // Next state, scores and winner
  always_comb begin
    state_d = state_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    win_d   = win_q;
    case (state_q)
      NEW_GAME: begin
        s1_d  = '0;
        s2_d  = '0;
        win_d = '0;
        if (serve) state_d = PLAY;
      end
      PLAY: begin
        if (bus.player_1_point) begin
          s1_d = s1_q + 4'd1;
          if (s1_q == WIN_M1) begin
            state_d = GAME_OVER;
            win_d   = 2'b01;
          end else begin
            state_d = NEW_BALL;
          end
        end else if (bus.player_2_point) begin
          s2_d = s2_q + 4'd1;
          if (s2_q == WIN_M1) begin
            state_d = GAME_OVER;
            win_d   = 2'b10;
          end else begin
            state_d = NEW_BALL;
          end
        end
      end
      NEW_BALL: begin
`ifdef AUTO_SERVE_EN
        if (serve || cnt_q == LAST) state_d = PLAY;
`else
        if (serve) state_d = PLAY;
`endif
      end
      GAME_OVER: begin
        if (serve) begin
          state_d = NEW_GAME;
          s1_d    = '0;
          s2_d    = '0;
          win_d   = '0;
        end
      end
      default: begin
        state_d = NEW_GAME;
        s1_d    = '0;
        s2_d    = '0;
        win_d   = '0;
      end
    endcase
  end

  // State and score registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= NEW_GAME;
      s1_q    <= '0;
      s2_q    <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      win_q   <= win_d;
    end
  end

  assign bus.state   = state_q;
  assign bus.score_1 = s1_q;
  assign bus.score_2 = s2_q;
  assign bus.winner  = win_q;

endmodule

// File: tb/tb_game_fsm.sv
// Random + directed bench for game_fsm against a rule-level model.
// Two units share stimulus: WIN_SCORE=3 and WIN_SCORE=5.
module tb_game_fsm;

  localparam int SD = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn = 1'b0;
  logic p1  = 1'b0;
  logic p2  = 1'b0;

  int total = 0;
  int bad   = 0;

  game_fsm_if ifa ();
  game_fsm_if ifb ();

  assign ifa.btnC           = btn;
  assign ifa.player_1_point = p1;
  assign ifa.player_2_point = p2;
  assign ifb.btnC           = btn;
  assign ifb.player_1_point = p1;
  assign ifb.player_2_point = p2;

  game_fsm #(.WIN_SCORE(3), .SERVE_DELAY(SD)) u_a (
    .clk(clk), .reset(rst), .bus(ifa.slave)
  );
  game_fsm #(.WIN_SCORE(5), .SERVE_DELAY(SD)) u_b (
    .clk(clk), .reset(rst), .bus(ifb.slave)
  );

  always #5 clk = ~clk;

  // model: phase 0 new game, 1 play, 2 new ball, 3 game over
  int wsc[2] = '{3, 5};
  int ph[2], sc1[2], sc2[2], wn[2], nb[2];
  int n;
  bit h1, h2, h3;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_rst();
    n = 0;
    h1 = 0; h2 = 0; h3 = 0;
    for (int u = 0; u < 2; u++) begin
      ph[u] = 0; sc1[u] = 0; sc2[u] = 0; wn[u] = 0; nb[u] = 0;
    end
  endtask

  task automatic model_edge();
    bit srv;
    if (!rst) return;
    n++;
    // a rise between two post-reset samples serves 2 edges later
    srv = (n >= 4) && h2 && !h3;
    h3 = h2; h2 = h1; h1 = btn;
    for (int u = 0; u < 2; u++) begin
      case (ph[u])
        0: begin
          sc1[u] = 0; sc2[u] = 0; wn[u] = 0;
          if (srv) ph[u] = 1;
        end
        1: begin
          if (p1) begin
            sc1[u]++;
            if (sc1[u] == wsc[u]) begin ph[u] = 3; wn[u] = 1; end
            else begin ph[u] = 2; nb[u] = 0; end
          end else if (p2) begin
            sc2[u]++;
            if (sc2[u] == wsc[u]) begin ph[u] = 3; wn[u] = 2; end
            else begin ph[u] = 2; nb[u] = 0; end
          end
        end
        2: begin
          nb[u]++;
`ifdef AUTO_SERVE_EN
          if (srv || nb[u] == SD) ph[u] = 1;
`else
          if (srv) ph[u] = 1;
`endif
        end
        default: begin
          if (srv) begin
            ph[u] = 0; sc1[u] = 0; sc2[u] = 0; wn[u] = 0;
          end
        end
      endcase
    end
  endtask

  task automatic check_all();
    chk("a_state", int'(ifa.state), 1 << ph[0]);
    chk("a_s1", int'(ifa.score_1), sc1[0]);
    chk("a_s2", int'(ifa.score_2), sc2[0]);
    chk("a_win", int'(ifa.winner), wn[0]);
    chk("b_state", int'(ifb.state), 1 << ph[1]);
    chk("b_s1", int'(ifb.score_1), sc1[1]);
    chk("b_s2", int'(ifb.score_2), sc2[1]);
    chk("b_win", int'(ifb.winner), wn[1]);
  endtask

  task automatic step(input bit b, input bit a, input bit c);
    btn = b; p1 = a; p2 = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  // reset asserted away from the edge; outputs must clear at once
  task automatic do_reset(input int cyc);
    rst = 1'b0;
    model_rst();
    #1;
    check_all();
    for (int i = 0; i < cyc; i++) step(btn, 1'b0, 1'b0);
    rst = 1'b1;
  endtask

  task automatic serve_until(input bit useb);
    for (int k = 0; k < 6; k++) begin
      step(1, 0, 0);
      step(1, 0, 0);
      repeat (4) step(0, 0, 0);
      if ((useb ? ifb.state : ifa.state) == 4'b0010) break;
    end
  endtask

  task automatic point(input bit a, input bit c);
    step(0, a, c);
    step(0, 0, 0);
  endtask

  initial begin
    int lat;
    model_rst();
    @(negedge clk);
    do_reset(3);
    repeat (3) step(0, 0, 0);

    // serve latency from pin rise
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 0);
      if (ifa.state == 4'b0010) begin lat = i; break; end
    end
    chk("serve_lat", lat, 3);
    repeat (3) step(0, 0, 0);

    // held point counts once
    repeat (5) step(0, 1, 0);
    repeat (12) step(0, 0, 0);
    serve_until(0);

    // simultaneous points: player 1 only
    point(1, 1);
    serve_until(0);

    // player 2 wins unit A
    point(0, 1);
    serve_until(0);
    point(0, 1);
    serve_until(0);
    point(0, 1);
    repeat (3) step(0, 0, 0);
    serve_until(1);

    // unit B reaches 4 points for player 1, then reset in PLAY
    point(1, 0);
    serve_until(1);
    point(1, 0);
    serve_until(1);
    @(negedge clk);
    check_all();
    do_reset(2);

    // button held through reset must not serve
    btn = 1'b1;
    do_reset(2);
    repeat (8) step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    serve_until(0);

    // random play
    for (int i = 0; i < 3000; i++) begin
      bit nb_, a, c;
      nb_ = ($urandom % 12 == 0) ? ~btn : btn;
      a = ($urandom % 6 == 0);
      c = ($urandom % 6 == 0);
      if ($urandom % 700 == 0) do_reset(1 + $urandom % 3);
      step(nb_, a, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
